// File: rtl/packer_pkg.sv
// Shared types and constants for the RGB24 -> 32-bit AXI4-Stream packer.
package packer_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = WORD_W / 8;
  localparam int unsigned PIX_W      = 24;

  typedef logic [1:0] phase_t;

  localparam logic [WORD_BYTES-1:0] KEEP_1B = 4'b0001;
  localparam logic [WORD_BYTES-1:0] KEEP_2B = 4'b0011;
  localparam logic [WORD_BYTES-1:0] KEEP_3B = 4'b0111;
  localparam logic [WORD_BYTES-1:0] KEEP_4B = 4'b1111;

  typedef struct packed {
    logic [WORD_W-1:0]     tdata;
    logic [WORD_BYTES-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;
  } out_word_t;

  // Bytes left pending in the residue before a pixel is packed at phase p.
  function automatic logic [1:0] residue_bytes(input phase_t p);
    case (p)
      2'd1:    residue_bytes = 2'd3;
      2'd2:    residue_bytes = 2'd2;
      2'd3:    residue_bytes = 2'd1;
      default: residue_bytes = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry word FIFO; entry 0 is the output head, accepts up to two pushes per cycle.
module axis_fifo2
  import packer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] push_cnt_i,
  input  out_word_t  push0_i,
  input  out_word_t  push1_i,
  input  logic       pop_i,
  output out_word_t  head_o,
  output logic       valid_o,
  output logic [1:0] free_o
);

  out_word_t e0_q, e0_d, e1_q, e1_d;
  logic      v0_q, v0_d, v1_q, v1_d;
  logic      pop;

  assign pop     = pop_i && v0_q;
  assign head_o  = e0_q;
  assign valid_o = v0_q;
  // Free slots as seen by this cycle's push, counting a same-cycle pop.
  assign free_o  = 2'd2 - (2'(v0_q) + 2'(v1_q)) + 2'(pop);

  always_comb begin
    e0_d = '0;
    e1_d = '0;
    v0_d = 1'b0;
    v1_d = 1'b0;
    if (pop) begin
      if (v1_q) begin
        e0_d = e1_q;
        v0_d = 1'b1;
      end
    end else begin
      e0_d = e0_q;
      v0_d = v0_q;
      e1_d = e1_q;
      v1_d = v1_q;
    end
    // Append new words behind whatever survived the pop; empty slots stay zero.
    if (!v0_d) begin
      if (push_cnt_i >= 2'd1) begin
        e0_d = push0_i;
        v0_d = 1'b1;
      end
      if (push_cnt_i >= 2'd2) begin
        e1_d = push1_i;
        v1_d = 1'b1;
      end
    end else if (!v1_d && (push_cnt_i >= 2'd1)) begin
      e1_d = push0_i;
      v1_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

endmodule

// File: rtl/rgb24_axis_packer.sv
// Packs 24-bit RGB pixels four-into-three onto a 32-bit AXI4-Stream with sof->tuser, eol->tlast.
// Define PACKER_PIXEL_COUNT_EN to add the pix_count accepted-pixel counter port.
module rgb24_axis_packer
  import packer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  input  logic                  valid,
  input  logic                  sof,
  input  logic                  eol,
  output logic                  in_stream_ready,
  output logic [DATA_W-1:0]     out_stream_tdata,
  output logic [DATA_W/8-1:0]   out_stream_tkeep,
  output logic                  out_stream_tlast,
  output logic                  out_stream_tuser,
  output logic                  out_stream_tvalid,
  input  logic                  out_stream_tready
`ifdef PACKER_PIXEL_COUNT_EN
  ,
  output logic [31:0]           pix_count
`endif
);

  phase_t              phase_q, phase_d, phase_eff;
  logic [PIX_W-1:0]    res_q, res_d, res_use;
  logic                sof_pend_q, sof_pend_d;
  logic [1:0]          res_n;
  logic [2*PIX_W-1:0]  cat;
  logic                accept;
  logic [1:0]          push_cnt;
  logic [1:0]          fifo_free;
  out_word_t           w0, w1, head;

  assign in_stream_ready = !areset && (fifo_free >= 2'd2);
  assign accept          = valid && in_stream_ready;

  // A sof pixel restarts the group: phase 0 and stale residue dropped.
  assign phase_eff = sof ? 2'd0 : phase_q;
  assign res_use   = sof ? '0 : res_q;
  assign res_n     = residue_bytes(phase_eff);
  assign cat       = ({24'd0, b, g, r} << {res_n, 3'b000}) | {24'd0, res_use};

  always_comb begin
    phase_d    = phase_q;
    res_d      = res_q;
    sof_pend_d = sof_pend_q;
    push_cnt   = 2'd0;
    w0         = '0;
    w1         = '0;
    if (accept) begin
      w0.tdata = cat[31:0];
      w0.tkeep = KEEP_4B;
      w0.tuser = sof || sof_pend_q;
      w1.tdata = {16'd0, cat[47:32]};
      if (eol) begin
        phase_d = 2'd0;
        res_d   = '0;
        case (phase_eff)
          2'd0: begin
            push_cnt = 2'd1;
            w0.tkeep = KEEP_3B;
            w0.tlast = 1'b1;
          end
          2'd1: begin
            push_cnt = 2'd2;
            w1.tkeep = KEEP_2B;
            w1.tlast = 1'b1;
          end
          2'd2: begin
            push_cnt = 2'd2;
            w1.tkeep = KEEP_1B;
            w1.tlast = 1'b1;
          end
          default: begin
            push_cnt = 2'd1;
            w0.tlast = 1'b1;
          end
        endcase
      end else begin
        phase_d = phase_t'(phase_eff + 2'd1);
        if (phase_eff == 2'd0) begin
          res_d = cat[23:0];
        end else begin
          push_cnt = 2'd1;
          res_d    = {8'd0, cat[47:32]};
        end
      end
      // tuser rides on the first word that carries the sof pixel's bytes.
      sof_pend_d = (push_cnt != 2'd0) ? 1'b0 : (sof || sof_pend_q);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase_q    <= 2'd0;
      res_q      <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      res_q      <= res_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  axis_fifo2 u_fifo (
    .clk_i      (aclk),
    .rst_i      (areset),
    .push_cnt_i (push_cnt),
    .push0_i    (w0),
    .push1_i    (w1),
    .pop_i      (out_stream_tvalid && out_stream_tready),
    .head_o     (head),
    .valid_o    (out_stream_tvalid),
    .free_o     (fifo_free)
  );

  assign out_stream_tdata = head.tdata;
  assign out_stream_tkeep = head.tkeep;
  assign out_stream_tlast = head.tlast;
  assign out_stream_tuser = head.tuser;

`ifdef PACKER_PIXEL_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = sof ? 32'd1 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pix_count = cnt_q;
`endif

endmodule
